// File: rtl/dispense_pkg.sv
// Shared encodings and default timing for the dispense path.
// The default timing constants are shared with main_controller and the benches.
package dispense_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MOTOR     = 3'd1,
        ST_WAIT_DROP = 3'd2,
        ST_GUARD     = 3'd3,
        ST_JAMMED    = 3'd4
    } state_e;

    localparam int DEF_NUM_REQ      = 2;
    localparam int DEF_ITEM_W       = 4;
    localparam int DEF_MOTOR_CYCLES = 8;
    localparam int DEF_DROP_TIMEOUT = 32;
    localparam int DEF_GUARD_CYCLES = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request strictly after ptr_i,
// wrapping around, so the last winner has the lowest priority.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               vld_o
);

    always_comb begin
        int c;
        vld_o = 1'b0;
        idx_o = '0;
        gnt_o = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            c = int'(ptr_i) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!vld_o && req_i[IDX_W'(c)]) begin
                vld_o = 1'b1;
                idx_o = IDX_W'(c);
            end
        end
        gnt_o[idx_o] = vld_o;
    end

endmodule

// File: rtl/dispense_scheduler.sv
// Sequences the shared dispense motor: round-robin grant, fixed motor pulse,
// drop-sensor wait with timeout, guard gap, and a jam lock cleared by cfg_mode.
module dispense_scheduler
    import dispense_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int ITEM_W       = DEF_ITEM_W,
    parameter int MOTOR_CYCLES = DEF_MOTOR_CYCLES,
    parameter int DROP_TIMEOUT = DEF_DROP_TIMEOUT,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      cfg_mode,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ITEM_W-1:0] req_item,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      motor_en,
    output logic [ITEM_W-1:0]         motor_sel,
    input  logic                      drop_sensor,
    output logic                      done,
    output logic                      fault,
    output logic                      busy,
    output logic                      jammed
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(max3(MOTOR_CYCLES, DROP_TIMEOUT, GUARD_CYCLES) + 1);
    localparam logic [CNT_W-1:0] MOTOR_TC = CNT_W'(MOTOR_CYCLES);
    localparam logic [CNT_W-1:0] DROP_TC  = CNT_W'(DROP_TIMEOUT);
    localparam logic [CNT_W-1:0] GUARD_TC = CNT_W'(GUARD_CYCLES);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                drop_seen_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic                motor_en_q, done_q, fault_q, busy_q, jammed_q;
    logic [ITEM_W-1:0]   motor_sel_q;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_vld;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    // cnt_q holds the 1-based index of the current cycle within MOTOR/WAIT_DROP/GUARD
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            drop_seen_q <= 1'b0;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            motor_en_q  <= 1'b0;
            motor_sel_q <= '0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            busy_q      <= 1'b0;
            jammed_q    <= 1'b0;
        end else begin
            gnt_q   <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (!cfg_mode && arb_vld) begin
                    state_q     <= ST_MOTOR;
                    gnt_q       <= arb_gnt;
                    motor_en_q  <= 1'b1;
                    motor_sel_q <= req_item[int'(arb_idx)*ITEM_W +: ITEM_W];
                    ptr_q       <= arb_idx;
                    cnt_q       <= CNT_W'(1);
                    drop_seen_q <= 1'b0;
                    busy_q      <= 1'b1;
                end
                ST_MOTOR: begin
                    if (drop_sensor) drop_seen_q <= 1'b1;
                    if (cnt_q >= MOTOR_TC) begin
                        state_q    <= ST_WAIT_DROP;
                        motor_en_q <= 1'b0;
                        cnt_q      <= CNT_W'(1);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT_DROP: begin
                    // a drop on the timeout cycle still counts as success
                    if (drop_seen_q || drop_sensor) begin
                        state_q     <= ST_GUARD;
                        done_q      <= 1'b1;
                        cnt_q       <= CNT_W'(1);
                        drop_seen_q <= 1'b0;
                    end else if (cnt_q >= DROP_TC) begin
                        state_q  <= ST_JAMMED;
                        fault_q  <= 1'b1;
                        jammed_q <= 1'b1;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (cnt_q >= GUARD_TC) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        motor_sel_q <= '0;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_JAMMED: if (cfg_mode) begin
                    state_q     <= ST_IDLE;
                    jammed_q    <= 1'b0;
                    busy_q      <= 1'b0;
                    motor_sel_q <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign motor_en  = motor_en_q;
    assign motor_sel = motor_sel_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign busy      = busy_q;
    assign jammed    = jammed_q;

endmodule

// File: tb/tb_dispense_scheduler.sv
// Bench for dispense_scheduler: directed table, hand-written corner sequences,
// and random dispenses predicted by a transaction-level timing model.
module tb_dispense_scheduler;

    localparam int N  = 2;
    localparam int IW = 4;
    localparam int M  = 8;
    localparam int T  = 32;
    localparam int G  = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            cfg_mode = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*IW-1:0] req_item = '0;
    logic [N-1:0]    gnt;
    logic            motor_en;
    logic [IW-1:0]   motor_sel;
    logic            drop_sensor = 1'b0;
    logic            done, fault, busy, jammed;

    int n_chk = 0;
    int n_fail = 0;
    int rr_last = N - 1;

    dispense_scheduler #(
        .NUM_REQ(N), .ITEM_W(IW), .MOTOR_CYCLES(M),
        .DROP_TIMEOUT(T), .GUARD_CYCLES(G)
    ) dut (
        .clk(clk), .rstn(rstn), .cfg_mode(cfg_mode), .req(req),
        .req_item(req_item), .gnt(gnt), .motor_en(motor_en),
        .motor_sel(motor_sel), .drop_sensor(drop_sensor), .done(done),
        .fault(fault), .busy(busy), .jammed(jammed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    r;
        logic [N*IW-1:0] items;
        int              drop_at;
        logic            hold;
        logic [N-1:0]    exp_gnt;
        logic [IW-1:0]   exp_sel;
        int              exp_evt;
        logic            exp_fault;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Round-robin rule: first set request at or after (last winner + 1) mod N.
    function automatic int model_pick(input logic [N-1:0] r);
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (rr_last + i) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // Cycle numbers count from 1 = first motor_en cycle; drop_at = cycle whose
    // closing edge samples drop_sensor high (0 = never).
    function automatic int model_evt(input int drop_at, output logic is_fault);
        is_fault = 1'b0;
        if (drop_at >= 1 && drop_at <= M) return M + 2;
        if (drop_at > M && drop_at <= M + T) return drop_at + 1;
        is_fault = 1'b1;
        return M + T + 1;
    endfunction

    // Called at a negedge with the DUT idle; returns at the first idle cycle
    // (success) or one cycle after the fault pulse.
    task automatic dispense(input logic [N-1:0] r, input logic [N*IW-1:0] items,
                            input int drop_at, input logic hold, input logic midcfg,
                            input logic [N-1:0] exp_gnt, input logic [IW-1:0] exp_sel,
                            input int exp_evt, input logic exp_fault);
        int n = 0, motor_cnt = 0, gnt_cnt = 0, done_n = 0, fault_n = 0;
        int done_cnt = 0, fault_cnt = 0, both = 0, idle_n = 0;
        req = r;
        req_item = items;
        while (n < 120) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("gnt", 32'(gnt), 32'(exp_gnt));
                check("motor_sel", 32'(motor_sel), 32'(exp_sel));
                if (!hold) req = '0;
            end
            if (gnt != 0) gnt_cnt++;
            if (motor_en) motor_cnt++;
            if (done) begin done_cnt++; done_n = n; end
            if (fault) begin fault_cnt++; fault_n = n; end
            if (done && fault) both++;
            drop_sensor = (n == drop_at);
            if (midcfg && n == 2) cfg_mode = 1'b1;
            if (!exp_fault && n > 1 && !busy) begin idle_n = n; break; end
            if (exp_fault && fault_n != 0 && n == fault_n + 1) begin
                check("jammed_set", 32'(jammed), 32'd1);
                check("jam_sel_hold", 32'(motor_sel), 32'(exp_sel));
                break;
            end
        end
        drop_sensor = 1'b0;
        if (midcfg) cfg_mode = 1'b0;
        if (n >= 120) check("dispense_timeout", 32'(n), 32'd0);
        check("gnt_count", 32'(gnt_cnt), 32'd1);
        check("motor_cycles", 32'(motor_cnt), 32'(M));
        check("done_and_fault", 32'(both), 32'd0);
        if (exp_fault) begin
            check("fault_cycle", 32'(fault_n), 32'(exp_evt));
            check("fault_count", 32'(fault_cnt), 32'd1);
            check("done_count", 32'(done_cnt), 32'd0);
        end else begin
            check("done_cycle", 32'(done_n), 32'(exp_evt));
            check("done_count", 32'(done_cnt), 32'd1);
            check("fault_count", 32'(fault_cnt), 32'd0);
            check("idle_cycle", 32'(idle_n), 32'(exp_evt + G));
        end
        for (int i = 0; i < N; i++) if (exp_gnt[i]) rr_last = i;
    endtask

    task automatic clear_jam();
        req = '0;
        @(negedge clk);
        cfg_mode = 1'b1;
        @(negedge clk);
        cfg_mode = 1'b0;
        check("jam_clear_jammed", 32'(jammed), 32'd0);
        check("jam_clear_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int gcnt;
        logic [N-1:0]    r;
        logic [N*IW-1:0] items;
        int              d, w, evt;
        logic            isf;

        tbl[0] = '{2'b01, 8'h95, 11, 1'b0, 2'b01, 4'h5, 12, 1'b0};
        tbl[1] = '{2'b11, 8'h93,  2, 1'b1, 2'b10, 4'h9, 10, 1'b0};
        tbl[2] = '{2'b11, 8'h93, 40, 1'b1, 2'b01, 4'h3, 41, 1'b0};
        tbl[3] = '{2'b11, 8'h93,  9, 1'b0, 2'b10, 4'h9, 10, 1'b0};
        tbl[4] = '{2'b01, 8'h95,  0, 1'b0, 2'b01, 4'h5, 41, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_motor_en", 32'(motor_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_jammed", 32'(jammed), 32'd0);
        check("rst_done_fault", 32'({done, fault}), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            dispense(tbl[i].r, tbl[i].items, tbl[i].drop_at, tbl[i].hold, 1'b0,
                     tbl[i].exp_gnt, tbl[i].exp_sel, tbl[i].exp_evt, tbl[i].exp_fault);

        // jammed: requests ignored until a service-mode pulse
        req = 2'b01;
        gcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (gnt != 0) gcnt++;
        end
        check("jam_no_gnt", 32'(gcnt), 32'd0);
        check("jam_hold", 32'(jammed), 32'd1);
        check("jam_busy", 32'(busy), 32'd1);
        cfg_mode = 1'b1;
        @(negedge clk);
        cfg_mode = 1'b0;
        check("jam_clear_jammed", 32'(jammed), 32'd0);
        check("jam_clear_busy", 32'(busy), 32'd0);
        dispense(2'b10, 8'h7A, 5, 1'b0, 1'b0, 2'b10, 4'h7, M + 2, 1'b0);

        // service mode blocks grants, then mid-MOTOR service mode does not abort
        cfg_mode = 1'b1;
        req = 2'b01;
        gcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (gnt != 0 || busy) gcnt++;
        end
        check("cfg_block", 32'(gcnt), 32'd0);
        cfg_mode = 1'b0;
        dispense(2'b01, 8'h7C, 15, 1'b0, 1'b1, 2'b01, 4'hC, 16, 1'b0);

        // asynchronous reset in the middle of MOTOR
        req = 2'b01;
        req_item = 8'h27;
        @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);
        check("pre_rst_motor_en", 32'(motor_en), 32'd1);
        #1 rstn = 1'b0;
        #1;
        check("async_rst_motor_en", 32'(motor_en), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_gnt", 32'(gnt), 32'd0);
        check("async_rst_sel", 32'(motor_sel), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        rr_last = N - 1;
        dispense(2'b11, 8'h62, 5, 1'b0, 1'b0, 2'b01, 4'h2, M + 2, 1'b0);

        // random dispenses against the timing model
        for (int it = 0; it < 25; it++) begin
            r = N'($urandom_range(1, (1 << N) - 1));
            items = (N*IW)'($urandom);
            d = $urandom_range(0, M + T + 3);
            w = model_pick(r);
            evt = model_evt(d, isf);
            dispense(r, items, d, 1'b0, 1'b0, N'(1 << w), items[w*IW +: IW], evt, isf);
            if (isf) clear_jam();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
